// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the hazard stall controller.
// Opcode, forwarding-select and FSM state constants.
package hazard_stall_ctrl_pkg;

    localparam logic [5:0] OP_BEQ = 6'b000100;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

endpackage

// File: rtl/hazard_need_calc.sv
// Combinational bubble count for the instruction in ID.
// Table selected by HAZ_FWD_EN (forwarding) or the no-forwarding default.
module hazard_need_calc
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int OP_W     = 6,
    parameter int LOAD_LAT = 1,
    parameter int NW       = 2
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              uses_rt,
    input  logic              id_ex_rw,
    input  logic              id_ex_mr,
    input  logic [REG_AW-1:0] id_ex_dst,
    input  logic              ex_mem_rw,
    input  logic              ex_mem_mr,
    input  logic [REG_AW-1:0] ex_mem_dst,
    output logic [NW-1:0]     need
);

    localparam logic [NW-1:0] N_L1 = NW'(LOAD_LAT + 1);
    localparam logic [NW-1:0] N_L0 = NW'(LOAD_LAT);
    localparam logic [NW-1:0] N_LM = NW'(LOAD_LAT - 1);

    logic          m1;
    logic          m2;
    logic [NW-1:0] n1;
    logic [NW-1:0] n2;

    assign m1 = id_ex_rw && (id_ex_dst != '0) &&
                ((id_ex_dst == rs) || (uses_rt && id_ex_dst == rt));
    assign m2 = ex_mem_rw && (ex_mem_dst != '0) &&
                ((ex_mem_dst == rs) || (uses_rt && ex_mem_dst == rt));

`ifdef HAZ_FWD_EN
    logic br;
    assign br = (opcode == OP_W'(OP_BEQ));

    always_comb begin
        n1 = '0;
        n2 = '0;
        if (m1) begin
            if (id_ex_mr) n1 = br ? N_L1 : N_L0;
            else          n1 = br ? NW'(1) : '0;
        end
        if (m2 && ex_mem_mr) n2 = br ? N_L0 : N_LM;
    end
`else
    logic unused_calc;
    assign unused_calc = ^{opcode, id_ex_mr, ex_mem_mr, N_LM};

    always_comb begin
        n1 = m1 ? N_L1 : '0;
        n2 = m2 ? N_L0 : '0;
    end
`endif

    assign need = (n1 > n2) ? n1 : n2;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Counted multi-cycle hazard stall controller with freeze and stall counter.
// Define HAZ_FWD_EN to enable forwarding selects and the forwarding bubble table.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int OP_W     = 6,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   Opcode,
    input  logic [REG_AW-1:0] IF_ID_RegRs,
    input  logic [REG_AW-1:0] IF_ID_RegRt,
    input  logic              ID_Uses_Rt,
    input  logic [REG_AW-1:0] ID_EX_RegRs,
    input  logic [REG_AW-1:0] ID_EX_RegRt,
    input  logic              ID_EX_RW,
    input  logic              ID_EX_MR,
    input  logic [REG_AW-1:0] ID_EX_RegDst,
    input  logic              EX_MEM_RW,
    input  logic              EX_MEM_MR,
    input  logic [REG_AW-1:0] EX_MEM_RegDst,
    input  logic              MEM_WB_RW,
    input  logic [REG_AW-1:0] MEM_WB_RegDst,
    input  logic              Mem_Busy,
    input  logic              Branch_Taken,
    output logic              IF_ID_Write_Zero,
    output logic              PC_Sub_4,
    output logic              Ctrl_0,
    output logic              IF_ID_Flush,
    output logic              Pipe_Freeze,
    output logic [CNT_W-1:0]  Stall_Cycles,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              ForwardBrA,
    output logic              ForwardBrB
);

    localparam int NW = $clog2(LOAD_LAT + 2);

    logic [NW-1:0] need;
    logic [NW-1:0] cnt;
    logic [0:0]    state;
    logic          hold;

    hazard_need_calc #(
        .REG_AW  (REG_AW),
        .OP_W    (OP_W),
        .LOAD_LAT(LOAD_LAT),
        .NW      (NW)
    ) u_need (
        .opcode    (Opcode),
        .rs        (IF_ID_RegRs),
        .rt        (IF_ID_RegRt),
        .uses_rt   (ID_Uses_Rt),
        .id_ex_rw  (ID_EX_RW),
        .id_ex_mr  (ID_EX_MR),
        .id_ex_dst (ID_EX_RegDst),
        .ex_mem_rw (EX_MEM_RW),
        .ex_mem_mr (EX_MEM_MR),
        .ex_mem_dst(EX_MEM_RegDst),
        .need      (need)
    );

    always_comb begin
        hold        = 1'b0;
        Pipe_Freeze = 1'b0;
        IF_ID_Flush = 1'b0;
        if (!rst) begin
            if (Mem_Busy) Pipe_Freeze = 1'b1;
            else if (state == ST_STALL || need != '0) hold = 1'b1;
            else if (Branch_Taken) IF_ID_Flush = 1'b1;
        end
    end

    assign IF_ID_Write_Zero = hold;
    assign PC_Sub_4         = hold;
    assign Ctrl_0           = hold;

    // Memory busy freezes state and remaining count alike.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else if (!Mem_Busy) begin
            if (state == ST_RUN) begin
                if (need != '0) begin
                    cnt   <= need - NW'(1);
                    state <= (need > NW'(1)) ? ST_STALL : ST_RUN;
                end
            end else begin
                cnt <= cnt - NW'(1);
                if (cnt == NW'(1)) state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Stall_Cycles <= '0;
        end else if ((hold || Pipe_Freeze) && Stall_Cycles != '1) begin
            Stall_Cycles <= Stall_Cycles + CNT_W'(1);
        end
    end

`ifdef HAZ_FWD_EN
    logic exm_alu;
    logic wb_ok;
    assign exm_alu = EX_MEM_RW && !EX_MEM_MR && EX_MEM_RegDst != '0;
    assign wb_ok   = MEM_WB_RW && MEM_WB_RegDst != '0;

    always_comb begin
        ForwardA   = FWD_RF;
        ForwardB   = FWD_RF;
        ForwardBrA = 1'b0;
        ForwardBrB = 1'b0;
        if (!rst) begin
            if (exm_alu && EX_MEM_RegDst == ID_EX_RegRs)
                ForwardA = FWD_EXMEM;
            else if (wb_ok && MEM_WB_RegDst == ID_EX_RegRs)
                ForwardA = FWD_MEMWB;
            if (exm_alu && EX_MEM_RegDst == ID_EX_RegRt)
                ForwardB = FWD_EXMEM;
            else if (wb_ok && MEM_WB_RegDst == ID_EX_RegRt)
                ForwardB = FWD_MEMWB;
            ForwardBrA = exm_alu && EX_MEM_RegDst == IF_ID_RegRs;
            ForwardBrB = exm_alu && ID_Uses_Rt &&
                         EX_MEM_RegDst == IF_ID_RegRt;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ID_EX_RegRs, ID_EX_RegRt, MEM_WB_RW,
                          MEM_WB_RegDst, FWD_EXMEM, FWD_MEMWB};
    assign ForwardA   = FWD_RF;
    assign ForwardB   = FWD_RF;
    assign ForwardBrA = 1'b0;
    assign ForwardBrB = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: LOAD_LAT 1 and 2, plus a narrow counter.
// Expectations follow HAZ_FWD_EN when defined.
module tb_hazard_stall_ctrl;

`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [5:0] Opcode;
    logic [4:0] IF_ID_RegRs, IF_ID_RegRt;
    logic       ID_Uses_Rt;
    logic [4:0] ID_EX_RegRs, ID_EX_RegRt;
    logic       ID_EX_RW, ID_EX_MR;
    logic [4:0] ID_EX_RegDst;
    logic       EX_MEM_RW, EX_MEM_MR;
    logic [4:0] EX_MEM_RegDst;
    logic       MEM_WB_RW;
    logic [4:0] MEM_WB_RegDst;
    logic       Mem_Busy, Branch_Taken;

    logic        w1_iz, w1_pc, w1_c0, w1_fl, w1_fz, w1_bra, w1_brb;
    logic [31:0] w1_sc;
    logic [1:0]  w1_fa, w1_fb;
    logic        w2_iz, w2_pc, w2_c0, w2_fl, w2_fz, w2_bra, w2_brb;
    logic [31:0] w2_sc;
    logic [1:0]  w2_fa, w2_fb;
    logic        w3_iz, w3_pc, w3_c0, w3_fl, w3_fz, w3_bra, w3_brb;
    logic [2:0]  w3_sc;
    logic [1:0]  w3_fa, w3_fb;

    int tests = 0;
    int fails = 0;

    hazard_stall_ctrl #(.LOAD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .Opcode(Opcode),
        .IF_ID_RegRs(IF_ID_RegRs), .IF_ID_RegRt(IF_ID_RegRt),
        .ID_Uses_Rt(ID_Uses_Rt),
        .ID_EX_RegRs(ID_EX_RegRs), .ID_EX_RegRt(ID_EX_RegRt),
        .ID_EX_RW(ID_EX_RW), .ID_EX_MR(ID_EX_MR),
        .ID_EX_RegDst(ID_EX_RegDst),
        .EX_MEM_RW(EX_MEM_RW), .EX_MEM_MR(EX_MEM_MR),
        .EX_MEM_RegDst(EX_MEM_RegDst),
        .MEM_WB_RW(MEM_WB_RW), .MEM_WB_RegDst(MEM_WB_RegDst),
        .Mem_Busy(Mem_Busy), .Branch_Taken(Branch_Taken),
        .IF_ID_Write_Zero(w1_iz), .PC_Sub_4(w1_pc), .Ctrl_0(w1_c0),
        .IF_ID_Flush(w1_fl), .Pipe_Freeze(w1_fz), .Stall_Cycles(w1_sc),
        .ForwardA(w1_fa), .ForwardB(w1_fb),
        .ForwardBrA(w1_bra), .ForwardBrB(w1_brb)
    );

    hazard_stall_ctrl #(.LOAD_LAT(2)) u2 (
        .clk(clk), .rst(rst), .Opcode(Opcode),
        .IF_ID_RegRs(IF_ID_RegRs), .IF_ID_RegRt(IF_ID_RegRt),
        .ID_Uses_Rt(ID_Uses_Rt),
        .ID_EX_RegRs(ID_EX_RegRs), .ID_EX_RegRt(ID_EX_RegRt),
        .ID_EX_RW(ID_EX_RW), .ID_EX_MR(ID_EX_MR),
        .ID_EX_RegDst(ID_EX_RegDst),
        .EX_MEM_RW(EX_MEM_RW), .EX_MEM_MR(EX_MEM_MR),
        .EX_MEM_RegDst(EX_MEM_RegDst),
        .MEM_WB_RW(MEM_WB_RW), .MEM_WB_RegDst(MEM_WB_RegDst),
        .Mem_Busy(Mem_Busy), .Branch_Taken(Branch_Taken),
        .IF_ID_Write_Zero(w2_iz), .PC_Sub_4(w2_pc), .Ctrl_0(w2_c0),
        .IF_ID_Flush(w2_fl), .Pipe_Freeze(w2_fz), .Stall_Cycles(w2_sc),
        .ForwardA(w2_fa), .ForwardB(w2_fb),
        .ForwardBrA(w2_bra), .ForwardBrB(w2_brb)
    );

    hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(3)) u3 (
        .clk(clk), .rst(rst), .Opcode(Opcode),
        .IF_ID_RegRs(IF_ID_RegRs), .IF_ID_RegRt(IF_ID_RegRt),
        .ID_Uses_Rt(ID_Uses_Rt),
        .ID_EX_RegRs(ID_EX_RegRs), .ID_EX_RegRt(ID_EX_RegRt),
        .ID_EX_RW(ID_EX_RW), .ID_EX_MR(ID_EX_MR),
        .ID_EX_RegDst(ID_EX_RegDst),
        .EX_MEM_RW(EX_MEM_RW), .EX_MEM_MR(EX_MEM_MR),
        .EX_MEM_RegDst(EX_MEM_RegDst),
        .MEM_WB_RW(MEM_WB_RW), .MEM_WB_RegDst(MEM_WB_RegDst),
        .Mem_Busy(Mem_Busy), .Branch_Taken(Branch_Taken),
        .IF_ID_Write_Zero(w3_iz), .PC_Sub_4(w3_pc), .Ctrl_0(w3_c0),
        .IF_ID_Flush(w3_fl), .Pipe_Freeze(w3_fz), .Stall_Cycles(w3_sc),
        .ForwardA(w3_fa), .ForwardB(w3_fb),
        .ForwardBrA(w3_bra), .ForwardBrB(w3_brb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Opcode = '0;
        IF_ID_RegRs = '0; IF_ID_RegRt = '0; ID_Uses_Rt = 1'b0;
        ID_EX_RegRs = '0; ID_EX_RegRt = '0;
        ID_EX_RW = 1'b0; ID_EX_MR = 1'b0; ID_EX_RegDst = '0;
        EX_MEM_RW = 1'b0; EX_MEM_MR = 1'b0; EX_MEM_RegDst = '0;
        MEM_WB_RW = 1'b0; MEM_WB_RegDst = '0;
        Mem_Busy = 1'b0; Branch_Taken = 1'b0;
    endtask

    task automatic set_ld_beq();
        ID_EX_RW = 1'b1; ID_EX_MR = 1'b1; ID_EX_RegDst = 5'd2;
        IF_ID_RegRs = 5'd2; Opcode = 6'b000100;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #2;
        ID_EX_RW = 1'b1; ID_EX_RegDst = 5'd5; IF_ID_RegRs = 5'd5;
        Mem_Busy = 1'b1; Branch_Taken = 1'b1;
        #1;
        tests++;
        if ({w1_c0, w1_iz, w1_pc, w1_fl, w1_fz} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs got %b want 00000",
                     {w1_c0, w1_iz, w1_pc, w1_fl, w1_fz});
        end
        @(posedge clk);
        #1;
        tests++;
        if (w1_sc !== 32'd0 || w2_sc !== 32'd0) begin
            fails++;
            $display("FAIL reset_counter got %0d/%0d want 0", w1_sc, w2_sc);
        end
        clear_inputs();
        #2;
        rst = 1'b0;
        cyc();
    endtask

    task automatic run_vec(input string name,
                           input bit irw, input bit imr, input int idst,
                           input bit erw, input bit emr, input int edst,
                           input int rs, input int rt, input bit urt,
                           input bit br, input int e1, input int e2);
        int n1, n2, p1;
        logic [31:0] s1;
        n1 = 0; n2 = 0; p1 = 0;
        s1 = w1_sc;
        clear_inputs();
        ID_EX_RW = irw; ID_EX_MR = imr; ID_EX_RegDst = 5'(idst);
        EX_MEM_RW = erw; EX_MEM_MR = emr; EX_MEM_RegDst = 5'(edst);
        IF_ID_RegRs = 5'(rs); IF_ID_RegRt = 5'(rt); ID_Uses_Rt = urt;
        Opcode = br ? 6'b000100 : 6'b000000;
        for (int i = 0; i < 5; i++) begin
            #2;
            if (w1_c0) n1++;
            if (w2_c0) n2++;
            if (w1_pc && w1_iz) p1++;
            cyc();
            if (i == 0) clear_inputs();
        end
        tests++;
        if (n1 !== e1) begin
            fails++;
            $display("FAIL %s_L1 bubbles got %0d want %0d", name, n1, e1);
        end
        tests++;
        if (n2 !== e2) begin
            fails++;
            $display("FAIL %s_L2 bubbles got %0d want %0d", name, n2, e2);
        end
        tests++;
        if (p1 !== e1 || (w1_sc - s1) !== 32'(e1)) begin
            fails++;
            $display("FAIL %s_hold_cnt got %0d/%0d want %0d",
                     name, p1, w1_sc - s1, e1);
        end
    endtask

    task automatic test_need();
        run_vec("alu_d1_rs", 1,0,5, 0,0,0, 5,0,0,0,
                FWD ? 0 : 2, FWD ? 0 : 3);
        run_vec("alu_d1_rt_unused", 1,0,5, 0,0,0, 0,5,0,0, 0, 0);
        run_vec("alu_d1_rt", 1,0,5, 0,0,0, 0,5,1,0,
                FWD ? 0 : 2, FWD ? 0 : 3);
        run_vec("dst_r0", 1,0,0, 0,0,0, 0,0,1,0, 0, 0);
        run_vec("ld_d1", 1,1,2, 0,0,0, 2,0,0,0,
                FWD ? 1 : 2, FWD ? 2 : 3);
        run_vec("ld_d1_beq", 1,1,2, 0,0,0, 2,0,1,1, 2, 3);
        run_vec("alu_d1_beq", 1,0,2, 0,0,0, 2,0,1,1,
                FWD ? 1 : 2, FWD ? 1 : 3);
        run_vec("alu_d2", 0,0,0, 1,0,7, 7,0,0,0,
                FWD ? 0 : 1, FWD ? 0 : 2);
        run_vec("ld_d2", 0,0,0, 1,1,7, 7,0,0,0,
                FWD ? 0 : 1, FWD ? 1 : 2);
        run_vec("ld_d2_beq", 0,0,0, 1,1,7, 7,0,0,1, 1, 2);
        run_vec("d1alu_d2ld", 1,0,4, 1,1,6, 4,6,1,0,
                FWD ? 0 : 2, FWD ? 1 : 3);
        run_vec("no_write", 0,0,5, 0,0,0, 5,0,0,0, 0, 0);
    endtask

    task automatic test_freeze();
        logic [31:0] s1, s2;
        s1 = w1_sc; s2 = w2_sc;
        clear_inputs();
        set_ld_beq();
        cyc();
        clear_inputs();
        cyc();
        Mem_Busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            tests++;
            if (w2_fz !== 1'b1 || w2_c0 !== 1'b0 || w1_c0 !== 1'b0) begin
                fails++;
                $display("FAIL freeze_%0d fz=%b c0=%b/%b want 1 0 0",
                         i, w2_fz, w2_c0, w1_c0);
            end
            cyc();
        end
        Mem_Busy = 1'b0;
        #2;
        tests++;
        if (w2_c0 !== 1'b1 || w1_c0 !== 1'b0 || w2_fz !== 1'b0) begin
            fails++;
            $display("FAIL freeze_resume c0=%b/%b fz=%b want 1 0 0",
                     w2_c0, w1_c0, w2_fz);
        end
        cyc();
        #2;
        tests++;
        if (w2_c0 !== 1'b0) begin
            fails++;
            $display("FAIL freeze_done c0=%b want 0", w2_c0);
        end
        tests++;
        if ((w1_sc - s1) !== 32'd5 || (w2_sc - s2) !== 32'd6) begin
            fails++;
            $display("FAIL freeze_count got %0d/%0d want 5/6",
                     w1_sc - s1, w2_sc - s2);
        end
        cyc();
    endtask

    task automatic test_flush();
        clear_inputs();
        Branch_Taken = 1'b1;
        #2;
        tests++;
        if (w1_fl !== 1'b1 || w2_fl !== 1'b1 || w1_c0 !== 1'b0) begin
            fails++;
            $display("FAIL flush_taken fl=%b/%b c0=%b want 1 1 0",
                     w1_fl, w2_fl, w1_c0);
        end
        cyc();
        Branch_Taken = 1'b0;
        #2;
        tests++;
        if (w1_fl !== 1'b0) begin
            fails++;
            $display("FAIL flush_clear fl=%b want 0", w1_fl);
        end
        cyc();
        set_ld_beq();
        Branch_Taken = 1'b1;
        Mem_Busy = 1'b1;
        #2;
        tests++;
        if ({w1_fz, w1_c0, w1_fl} !== 3'b100) begin
            fails++;
            $display("FAIL flush_busy fz,c0,fl=%b want 100",
                     {w1_fz, w1_c0, w1_fl});
        end
        cyc();
        Mem_Busy = 1'b0;
        #2;
        tests++;
        if ({w1_c0, w1_fl, w2_c0, w2_fl} !== 4'b1010) begin
            fails++;
            $display("FAIL flush_hazard c0,fl=%b want 1010",
                     {w1_c0, w1_fl, w2_c0, w2_fl});
        end
        cyc();
        ID_EX_RW = 1'b0; ID_EX_MR = 1'b0;
        #2;
        tests++;
        if ({w1_c0, w1_fl, w2_c0, w2_fl} !== 4'b1010) begin
            fails++;
            $display("FAIL flush_in_stall c0,fl=%b want 1010",
                     {w1_c0, w1_fl, w2_c0, w2_fl});
        end
        clear_inputs();
        cyc(); cyc(); cyc();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        set_ld_beq();
        cyc();
        clear_inputs();
        #2;
        rst = 1'b1;
        Mem_Busy = 1'b1;
        #1;
        tests++;
        if ({w2_c0, w2_iz, w2_pc, w2_fz} !== 4'b0 || w2_sc !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid outs=%b sc=%0d want 0000 0",
                     {w2_c0, w2_iz, w2_pc, w2_fz}, w2_sc);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        Mem_Busy = 1'b0;
        #1;
        tests++;
        if (w2_c0 !== 1'b0 || w1_c0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run c0=%b/%b want 0 0", w1_c0, w2_c0);
        end
        cyc();
        #1;
        tests++;
        if (w2_c0 !== 1'b0 || w3_sc !== 3'd0) begin
            fails++;
            $display("FAIL reset_mid_after c0=%b sc=%0d want 0 0",
                     w2_c0, w3_sc);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] s1;
        clear_inputs();
        s1 = w1_sc;
        Mem_Busy = 1'b1;
        cyc(); cyc(); cyc();
        tests++;
        if (w3_sc !== 3'd3) begin
            fails++;
            $display("FAIL sat_partial got %0d want 3", w3_sc);
        end
        for (int i = 0; i < 8; i++) cyc();
        tests++;
        if (w3_sc !== 3'd7) begin
            fails++;
            $display("FAIL sat_hold got %0d want 7", w3_sc);
        end
        tests++;
        if ((w1_sc - s1) !== 32'd11) begin
            fails++;
            $display("FAIL sat_wide got %0d want 11", w1_sc - s1);
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        Mem_Busy = 1'b1;
        EX_MEM_RW = 1'b1; EX_MEM_RegDst = 5'd3; ID_EX_RegRs = 5'd3;
        #1;
        tests++;
        if (w1_fa !== (FWD ? 2'b01 : 2'b00) || w1_fb !== 2'b00) begin
            fails++;
            $display("FAIL fwd_exmem fa=%b fb=%b", w1_fa, w1_fb);
        end
        MEM_WB_RW = 1'b1; MEM_WB_RegDst = 5'd3; ID_EX_RegRt = 5'd3;
        #1;
        tests++;
        if (w1_fa !== (FWD ? 2'b01 : 2'b00) ||
            w1_fb !== (FWD ? 2'b01 : 2'b00)) begin
            fails++;
            $display("FAIL fwd_priority fa=%b fb=%b", w1_fa, w1_fb);
        end
        EX_MEM_MR = 1'b1;
        #1;
        tests++;
        if (w1_fa !== (FWD ? 2'b10 : 2'b00)) begin
            fails++;
            $display("FAIL fwd_memwb fa=%b want %b", w1_fa,
                     FWD ? 2'b10 : 2'b00);
        end
        MEM_WB_RegDst = 5'd0;
        #1;
        tests++;
        if (w1_fa !== 2'b00) begin
            fails++;
            $display("FAIL fwd_r0 fa=%b want 00", w1_fa);
        end
        EX_MEM_MR = 1'b0; IF_ID_RegRs = 5'd3;
        IF_ID_RegRt = 5'd3; ID_Uses_Rt = 1'b1;
        #1;
        tests++;
        if (w1_bra !== FWD || w1_brb !== FWD) begin
            fails++;
            $display("FAIL fwd_branch bra=%b brb=%b want %b",
                     w1_bra, w1_brb, FWD);
        end
        clear_inputs();
        cyc(); cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_need();
        test_freeze();
        test_flush();
        test_forward();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
